// File: rtl/memif_pkg.sv
// Shared types and default constants for the host-to-SRAM memory cycle engine.
// Optional feature macro: MEMIF_RO_FAULT_EN (sticky write-to-read-only flag).
package memif_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int SER_CH_DEF    = 2;
    localparam int BANK_BITS_DEF = 4;
    localparam int PAGE_W_DEF    = 7;
    localparam int WAIT_CYC_DEF  = 1;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SHIFT,
        DECODE,
        RD_WAIT,
        RD_HOLD,
        WR_WAIT,
        WR_COMMIT,
        DONE
    } state_t;

    typedef struct packed {
        logic cs_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '1;

endpackage

// File: rtl/memif_if.sv
// SRAM-side bus of the memory cycle engine; master = engine, slave = memory.
interface memif_if
    import memif_pkg::*;
#(
    parameter int AW = PAGE_W_DEF + ADDR_W_DEF - BANK_BITS_DEF - 1
);
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_din;
    logic [15:0]   sram_dout;
    logic          sram_doe;
    logic          sram_cs_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;

    modport master (
        output sram_addr, sram_dout, sram_doe,
        output sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  sram_din
    );

    modport slave (
        input  sram_addr, sram_dout, sram_doe,
        input  sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output sram_din
    );
endinterface

// File: rtl/memif_addr_shifter.sv
// Drives the external parallel-load shift registers (shld/serclk) and
// deserialises the host address, one MSB-first slice per channel.
module memif_addr_shifter
    import memif_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SER_CH = SER_CH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SER_CH-1:0] adrin,
    output logic              shld,
    output logic              serclk,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);
    localparam int N  = ADDR_W / SER_CH;
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  sr [SER_CH];
    logic [CW-1:0] count;
    logic          active;

    // One idle clock after the load pulse lets the external register settle
    // before the first serclk rise; data is sampled on the rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shld   <= 1'b1;
            serclk <= 1'b0;
            active <= 1'b0;
            count  <= '0;
            for (int c = 0; c < SER_CH; c++) sr[c] <= '0;
        end else if (start) begin
            shld   <= 1'b0;
            serclk <= 1'b0;
            active <= 1'b1;
            count  <= '0;
        end else if (!shld) begin
            shld <= 1'b1;
        end else if (active) begin
            if (!serclk) begin
                serclk <= 1'b1;
                count  <= count + 1'b1;
                for (int c = 0; c < SER_CH; c++) sr[c] <= {sr[c][N-2:0], adrin[c]};
            end else begin
                serclk <= 1'b0;
                if (count == CW'(N)) active <= 1'b0;
            end
        end
    end

    assign done = active && serclk && (count == CW'(N));

    for (genvar c = 0; c < SER_CH; c++) begin : g_slice
        assign addr[ADDR_W-1-c*N -: N] = sr[c];
    end

endmodule

// File: rtl/mem_cycle_engine.sv
// Host memory cycle engine: serial address capture, bank mapping and SRAM
// read/write sequencing. Optional MEMIF_RO_FAULT_EN adds a sticky ro_fault flag.
module mem_cycle_engine
    import memif_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int SER_CH    = SER_CH_DEF,
    parameter int BANK_BITS = BANK_BITS_DEF,
    parameter int PAGE_W    = PAGE_W_DEF,
    parameter int WAIT_CYC  = WAIT_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 phi3,
    input  logic                 memen,
    input  logic                 dbin,
    input  logic                 we,
    input  logic                 a15,
    input  logic [SER_CH-1:0]    adrin,
    output logic                 shld,
    output logic                 serclk,
    input  logic [7:0]           host_din,
    output logic [7:0]           host_dout,
    output logic                 host_doe,
    output logic [ADDR_W-1:0]    address_bus,
    output logic [BANK_BITS-1:0] bank_sel,
    input  logic                 bank_mapped,
    input  logic                 bank_readonly,
    input  logic [PAGE_W-1:0]    bank_address,
    memif_if.master              sram,
    output logic                 busy,
    output logic                 ro_fault
);
    localparam logic [3:0] RD_LAST = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
    localparam logic [3:0] WR_LAST = 4'(WAIT_CYC);

    state_t            state;
    strobes_t          strb;
    logic [3:0]        wait_cnt;
    logic [15:0]       rd_data;
    logic              shift_done;
    logic [ADDR_W-1:0] shift_addr;

    memif_addr_shifter #(.ADDR_W(ADDR_W), .SER_CH(SER_CH)) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .start  (state == IDLE && !phi3),
        .adrin  (adrin),
        .shld   (shld),
        .serclk (serclk),
        .done   (shift_done),
        .addr   (shift_addr)
    );

    // memen rising aborts any SRAM phase: strobes drop back to idle on DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            strb           <= STROBES_IDLE;
            wait_cnt       <= '0;
            rd_data        <= '0;
            address_bus    <= '0;
            bank_sel       <= '0;
            sram.sram_addr <= '0;
            sram.sram_dout <= '0;
            sram.sram_doe  <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (!phi3) state <= LOAD;
                LOAD:    state <= SHIFT;
                SHIFT: begin
                    if (shift_done) begin
                        address_bus <= shift_addr;
                        bank_sel    <= shift_addr[ADDR_W-1 -: BANK_BITS];
                        state       <= memen ? IDLE : DECODE;
                    end
                end
                DECODE: begin
                    sram.sram_addr <= {bank_address, address_bus[ADDR_W-BANK_BITS-1:1]};
                    wait_cnt       <= '0;
                    if (memen || !bank_mapped) begin
                        state <= DONE;
                    end else if (dbin) begin
                        strb  <= '{cs_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0};
                        state <= RD_WAIT;
                    end else begin
                        state <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (memen) begin
                        strb  <= STROBES_IDLE;
                        state <= DONE;
                    end else if (wait_cnt == RD_LAST) begin
                        rd_data <= sram.sram_din;
                        strb    <= STROBES_IDLE;
                        state   <= RD_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_HOLD: if (memen) state <= DONE;
                WR_WAIT: begin
                    if (memen) begin
                        state <= DONE;
                    end else if (we) begin
                        sram.sram_dout <= {host_din, host_din};
                        sram.sram_doe  <= 1'b1;
                        strb  <= '{cs_n: 1'b0, oe_n: 1'b1, we_n: bank_readonly, ub_n: a15, lb_n: !a15};
                        wait_cnt <= '0;
                        state    <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    if (memen || wait_cnt == WR_LAST) begin
                        strb          <= STROBES_IDLE;
                        sram.sram_doe <= 1'b0;
                        state         <= (!memen && !a15) ? WR_WAIT : DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    if (phi3 && memen) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMIF_RO_FAULT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ro_fault <= 1'b0;
        end else if (state == WR_WAIT && !memen && we && bank_readonly) begin
            ro_fault <= 1'b1;
        end
    end
`else
    assign ro_fault = 1'b0;
`endif

    assign sram.sram_cs_n = strb.cs_n;
    assign sram.sram_oe_n = strb.oe_n;
    assign sram.sram_we_n = strb.we_n;
    assign sram.sram_ub_n = strb.ub_n;
    assign sram.sram_lb_n = strb.lb_n;

    assign host_doe  = (state == RD_HOLD) && !memen && dbin;
    assign host_dout = a15 ? rd_data[7:0] : rd_data[15:8];
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_cycle_engine.sv
// Directed bench for mem_cycle_engine: a WAIT_CYC=1 instance plus a WAIT_CYC=3
// instance sharing the host inputs; honours MEMIF_RO_FAULT_EN when defined.
module tb_mem_cycle_engine;
    import memif_pkg::*;

    localparam int ADDR_W    = 16;
    localparam int SER_CH    = 2;
    localparam int BANK_BITS = 4;
    localparam int PAGE_W    = 7;
    localparam int SAW       = PAGE_W + ADDR_W - BANK_BITS - 1;
    localparam int N         = ADDR_W / SER_CH;
`ifdef MEMIF_RO_FAULT_EN
    localparam logic RO_FAULT_EXP = 1'b1;
`else
    localparam logic RO_FAULT_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, phi3, memen, dbin, we, a15;
    logic [SER_CH-1:0] adrin;
    logic [7:0] host_din;

    logic shld, serclk, host_doe, busy, ro_fault, bank_mapped, bank_readonly;
    logic [7:0] host_dout;
    logic [ADDR_W-1:0] address_bus;
    logic [BANK_BITS-1:0] bank_sel;
    logic [PAGE_W-1:0] bank_address;

    logic shld3, serclk3, host_doe3, busy3, ro_fault3, bank_mapped3, bank_readonly3;
    logic [7:0] host_dout3;
    logic [ADDR_W-1:0] address_bus3;
    logic [BANK_BITS-1:0] bank_sel3;
    logic [PAGE_W-1:0] bank_address3;

    int assertions = 0;
    int failures = 0;
    int sample_k = 0;
    logic [ADDR_W-1:0] shift_word = '0;
    int we_low, cs_low, oe_low, oe3_low;
    logic [1:0] lanes;
    logic [15:0] dout;
    logic [2:0] lanes_seen;
    logic [SAW-1:0] addr_seen;
    logic cs_seen;

    memif_if #(.AW(SAW)) mem ();
    memif_if #(.AW(SAW)) mem3 ();

    mem_cycle_engine #(.WAIT_CYC(1)) dut (
        .clk(clk), .reset(reset), .phi3(phi3), .memen(memen), .dbin(dbin), .we(we), .a15(a15),
        .adrin(adrin), .shld(shld), .serclk(serclk), .host_din(host_din), .host_dout(host_dout),
        .host_doe(host_doe), .address_bus(address_bus), .bank_sel(bank_sel),
        .bank_mapped(bank_mapped), .bank_readonly(bank_readonly), .bank_address(bank_address),
        .sram(mem), .busy(busy), .ro_fault(ro_fault)
    );

    mem_cycle_engine #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .reset(reset), .phi3(phi3), .memen(memen), .dbin(dbin), .we(we), .a15(a15),
        .adrin(adrin), .shld(shld3), .serclk(serclk3), .host_din(host_din), .host_dout(host_dout3),
        .host_doe(host_doe3), .address_bus(address_bus3), .bank_sel(bank_sel3),
        .bank_mapped(bank_mapped3), .bank_readonly(bank_readonly3), .bank_address(bank_address3),
        .sram(mem3), .busy(busy3), .ro_fault(ro_fault3)
    );

    always #5 clk = ~clk;

    // Mapper: bank 6 writable page 0x15, bank 2 read-only page 0x03, rest unmapped.
    function automatic logic [PAGE_W+1:0] map_lookup(input logic [BANK_BITS-1:0] bank);
        case (bank)
            4'd6:    return {1'b1, 1'b0, 7'h15};
            4'd2:    return {1'b1, 1'b1, 7'h03};
            default: return '0;
        endcase
    endfunction

    assign {bank_mapped, bank_readonly, bank_address}    = map_lookup(bank_sel);
    assign {bank_mapped3, bank_readonly3, bank_address3} = map_lookup(bank_sel3);

    // External shift register model: channel c presents bit k of its slice, MSB first.
    always @(negedge clk) begin
        if (!shld) sample_k = 0;
        else if (serclk) sample_k = sample_k + 1;
        for (int c = 0; c < SER_CH; c++)
            adrin[c] = (sample_k < N) ? shift_word[ADDR_W-1-c*N-sample_k] : 1'b0;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; phi3 = 1'b1; memen = 1'b1; dbin = 1'b0; we = 1'b0; a15 = 1'b0;
        host_din = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic mem_cycle, input logic rd);
        shift_word = addr;
        memen = ~mem_cycle;
        dbin = rd;
        phi3 = 1'b0;
        @(negedge clk);
        phi3 = 1'b1;
    endtask

    task automatic wait_address(input logic [15:0] addr, input string tag);
        for (int i = 0; i < 60 && address_bus !== addr; i++) @(negedge clk);
        check_output(tag, 32'(address_bus), 32'(addr));
    endtask

    task automatic watch_commit(output int wl, output int cl, output logic [1:0] ln, output logic [15:0] dv);
        wl = 0; cl = 0; ln = 2'b11; dv = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem.sram_cs_n == 1'b0) begin
                cl++;
                we = 1'b0;
                ln = {mem.sram_ub_n, mem.sram_lb_n};
                dv = mem.sram_dout;
                if (mem.sram_we_n == 1'b0) wl++;
            end else if (cl > 0) begin
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        mem.sram_din = 16'hBEEF;
        mem3.sram_din = 16'hBEEF;

        do_reset();
        check_output("rst_shld", 32'(shld), 32'd1);
        check_output("rst_serclk", 32'(serclk), 32'd0);
        check_output("rst_strobes", 32'({mem.sram_cs_n, mem.sram_oe_n, mem.sram_we_n, mem.sram_ub_n, mem.sram_lb_n}), 32'h1F);
        check_output("rst_doe", 32'({mem.sram_doe, host_doe}), 32'd0);
        check_output("rst_address_bus", 32'(address_bus), 32'd0);
        check_output("rst_bank_sel", 32'(bank_sel), 32'd0);
        check_output("rst_sram_addr", 32'(mem.sram_addr), 32'd0);
        check_output("rst_sram_dout", 32'(mem.sram_dout), 32'd0);
        check_output("rst_busy_ro", 32'({busy, ro_fault}), 32'd0);

        $display("[TB] read from bank 6");
        do_reset();
        apply_stimulus(16'h6A3C, 1'b1, 1'b1);
        wait_address(16'h6A3C, "rd_address_bus");
        check_output("rd_bank_sel", 32'(bank_sel), 32'd6);
        oe_low = 0; oe3_low = 0; lanes_seen = 3'b111; addr_seen = '0;
        for (int i = 0; i < 40 && host_doe3 !== 1'b1; i++) begin
            @(negedge clk);
            if (!mem.sram_oe_n) begin
                oe_low++;
                lanes_seen = {mem.sram_cs_n, mem.sram_ub_n, mem.sram_lb_n};
                addr_seen = mem.sram_addr;
            end
            if (!mem3.sram_oe_n) oe3_low++;
        end
        // {page 0x15, address bits [11:1] of 0x6A3C = 0x51E}
        check_output("rd_sram_addr", 32'(addr_seen), 32'({7'h15, 11'h51E}));
        check_output("rd_lanes", 32'(lanes_seen), 32'd0);
        check_output("rd_oe_clks_w1", 32'(oe_low), 32'd1);
        check_output("rd_oe_clks_w3", 32'(oe3_low), 32'd3);
        check_output("rd_host_doe", 32'({host_doe, host_doe3}), 32'h3);
        check_output("rd_dout_upper", 32'(host_dout), 32'hBE);
        a15 = 1'b1;
        #1;
        check_output("rd_dout_lower", 32'(host_dout), 32'hEF);
        check_output("rd_dout_lower_w3", 32'(host_dout3), 32'hEF);
        check_output("rd_strobes_released", 32'({mem.sram_cs_n, mem.sram_oe_n}), 32'h3);
        memen = 1'b1;
        #1;
        check_output("rd_doe_off", 32'(host_doe), 32'd0);
        @(negedge clk);
        check_output("rd_done_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_output("rd_idle_busy", 32'(busy), 32'd0);

        $display("[TB] two-byte write to bank 6");
        do_reset();
        apply_stimulus(16'h6124, 1'b1, 1'b0);
        wait_address(16'h6124, "wr_address_bus");
        a15 = 1'b0; host_din = 8'h12; we = 1'b1;
        watch_commit(we_low, cs_low, lanes, dout);
        check_output("wr1_we_clks", 32'(we_low), 32'd2);
        check_output("wr1_lanes", 32'(lanes), 32'b01);
        check_output("wr1_dout", 32'(dout), 32'h1212);
        check_output("wr1_busy", 32'(busy), 32'd1);
        a15 = 1'b1; host_din = 8'h34; we = 1'b1;
        watch_commit(we_low, cs_low, lanes, dout);
        check_output("wr2_we_clks", 32'(we_low), 32'd2);
        check_output("wr2_lanes", 32'(lanes), 32'b10);
        check_output("wr2_dout", 32'(dout), 32'h3434);
        check_output("wr_doe_off_ro", 32'({mem.sram_doe, ro_fault}), 32'd0);
        memen = 1'b1;
        repeat (2) @(negedge clk);
        check_output("wr_idle_busy", 32'(busy), 32'd0);

        $display("[TB] write to read-only bank 2");
        do_reset();
        apply_stimulus(16'h2010, 1'b1, 1'b0);
        wait_address(16'h2010, "ro_address_bus");
        a15 = 1'b1; host_din = 8'h55; we = 1'b1;
        watch_commit(we_low, cs_low, lanes, dout);
        check_output("ro_we_clks", 32'(we_low), 32'd0);
        check_output("ro_cs_clks", 32'(cs_low), 32'd2);
        check_output("ro_fault", 32'(ro_fault), 32'(RO_FAULT_EXP));
        memen = 1'b1;
        repeat (2) @(negedge clk);
        check_output("ro_fault_held", 32'(ro_fault), 32'(RO_FAULT_EXP));

        $display("[TB] unmapped bank 9");
        do_reset();
        apply_stimulus(16'h9ABC, 1'b1, 1'b1);
        wait_address(16'h9ABC, "um_address_bus");
        check_output("um_bank_sel", 32'(bank_sel), 32'd9);
        cs_seen = 1'b1;
        repeat (4) begin
            @(negedge clk);
            cs_seen = cs_seen & mem.sram_cs_n & mem.sram_oe_n;
        end
        check_output("um_no_strobe", 32'(cs_seen), 32'd1);
        check_output("um_busy_done", 32'(busy), 32'd1);
        memen = 1'b1;
        repeat (2) @(negedge clk);
        check_output("um_idle_busy", 32'(busy), 32'd0);

        $display("[TB] memen high during shift");
        do_reset();
        apply_stimulus(16'h5A5A, 1'b0, 1'b1);
        cs_seen = 1'b1;
        for (int i = 0; i < 60 && address_bus !== 16'h5A5A; i++) begin
            @(negedge clk);
            cs_seen = cs_seen & mem.sram_cs_n;
        end
        check_output("cru_address_bus", 32'(address_bus), 32'h5A5A);
        check_output("cru_bank_sel", 32'(bank_sel), 32'd5);
        check_output("cru_idle", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            cs_seen = cs_seen & mem.sram_cs_n;
        end
        check_output("cru_no_strobe", 32'(cs_seen), 32'd1);

        $display("[TB] reset during write commit");
        do_reset();
        apply_stimulus(16'h6124, 1'b1, 1'b0);
        wait_address(16'h6124, "mc_address_bus");
        a15 = 1'b0; host_din = 8'hA5; we = 1'b1;
        for (int i = 0; i < 10 && mem.sram_we_n !== 1'b0; i++) @(negedge clk);
        check_output("mc_we_low", 32'(mem.sram_we_n), 32'd0);
        reset = 1'b0;
        #1;
        check_output("mc_we_released", 32'(mem.sram_we_n), 32'd1);
        check_output("mc_busy", 32'(busy), 32'd0);
        check_output("mc_cs_doe", 32'({mem.sram_cs_n, mem.sram_doe}), 32'b10);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
